// File: rtl/bus_rx_endpoint.sv
// -----------------------------------------------------------------------------
// bus_rx_endpoint
//
// Receive endpoint on a shared byte bus. Every endpoint sees every header;
// the one whose NODE_ID matches the Gray-coded destination in the header
// buffers the payload bytes in a small FIFO for the local module. All other
// endpoints skip the frame until the next header.
//
// Header byte: [7:6] Gray-coded destination (00->0, 01->1, 11->2, 10->3)
//              [5:0] payload length minus one (1..64 bytes)
//
// Parameters
//   NODE_ID     destination ID this endpoint answers to
//   FIFO_DEPTH  receive FIFO entries (power of two, 2..16)
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       synchronous active-low reset
//   bus_valid   shared bus carries a byte this cycle
//   bus_sof     bus_data is a frame header (only meaningful with bus_valid)
//   bus_data    shared bus byte
//   bus_ready   this endpoint accepts the bus byte (ORed at top level)
//   bus_ack     one-cycle pulse after the last payload byte of our frame
//   rx_valid    FIFO head holds a byte for the local module
//   rx_ready    local module consumes the FIFO head
//   rx_data     FIFO head payload byte (0 while the FIFO is empty)
//   rx_last     FIFO head is the final byte of its frame
//   rx_err      one-cycle pulse: our frame was cut short by a new header
//   err_count   (only with BUS_RX_ERR_CNT_EN) saturating count of rx_err
//
// Optional feature macro: BUS_RX_ERR_CNT_EN adds the err_count output.
// -----------------------------------------------------------------------------
module bus_rx_endpoint #(
  parameter logic [1:0] NODE_ID    = 2'd0,
  parameter int         FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bus_valid,
  input  logic       bus_sof,
  input  logic [7:0] bus_data,
  output logic       bus_ready,
  output logic       bus_ack,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic [7:0] rx_data,
  output logic       rx_last,
  output logic       rx_err
`ifdef BUS_RX_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_SKIP = 2'd2
  } state_t;

  // Gray-coded destination field to binary node number.
  function automatic logic [1:0] gray2bin(input logic [1:0] g);
    return {g[1], g[1] ^ g[0]};
  endfunction

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        ack_q, ack_d;
  logic        err_q, err_d;
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]  mem_q [FIFO_DEPTH];
  logic [8:0]  push_entry_d;

  logic        fifo_empty;
  logic        fifo_full;
  logic        hdr_take;
  logic        dat_take;
  logic        push;
  logic        pop;
  logic [8:0]  head;

  // FIFO status from registered pointers; the extra MSB separates full from empty.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    head       = mem_q[rd_ptr_q[AW-1:0]];
  end

  // Output decode from registered state: ready per state, FIFO head view.
  always_comb begin
    case (state_q)
      ST_IDLE: bus_ready = 1'b1;
      ST_RECV: bus_ready = !fifo_full;
      ST_SKIP: bus_ready = 1'b0;
      default: bus_ready = 1'b0;
    endcase
    rx_valid = !fifo_empty;
    if (fifo_empty) begin
      rx_data = 8'd0;
      rx_last = 1'b0;
    end else begin
      rx_data = head[7:0];
      rx_last = head[8];
    end
    bus_ack = ack_q;
    rx_err  = err_q;
  end

  // Bus qualification. Headers are taken whenever they appear on the bus:
  // in SKIP our own bus_ready is 0, yet another endpoint accepts the header
  // and we must still follow it to leave SKIP.
  always_comb begin
    hdr_take = bus_valid && bus_sof;
    dat_take = bus_valid && !bus_sof && (state_q == ST_RECV) && !fifo_full;
    push     = dat_take;
    pop      = !fifo_empty && rx_ready;
    push_entry_d = {(cnt_q == 6'd0), bus_data};
  end

  // Next-state logic: frame tracking, remaining count, ack/err pulses.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    if (hdr_take) begin
      // A header while still receiving aborts our frame; entries already
      // in the FIFO are left exactly as they were pushed.
      err_d = (state_q == ST_RECV);
      if (gray2bin(bus_data[7:6]) == NODE_ID) begin
        state_d = ST_RECV;
        cnt_d   = bus_data[5:0];
      end else begin
        state_d = ST_SKIP;
        cnt_d   = 6'd0;
      end
    end else if (dat_take) begin
      if (cnt_q == 6'd0) begin
        state_d = ST_IDLE;
        ack_d   = 1'b1;
      end else begin
        cnt_d = cnt_q - 6'd1;
      end
    end else begin
      state_d = state_q;
      cnt_d   = cnt_q;
    end
  end

  // Pointer advance; a push is only ever offered when the FIFO is not full.
  always_comb begin
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // State register and control flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 6'd0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // FIFO storage; cleared on reset so no stale frame survives.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 9'd0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_entry_d;
    end
  end

`ifdef BUS_RX_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of abort pulses.
  always_comb begin
    if (err_q && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
    err_count = err_cnt_q;
  end

  // Error counter register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_bus_rx_endpoint.sv
// Bench: two endpoints (NODE_ID 0 and 2) on one shared bus, checked every
// cycle against a frame/queue-level model, plus literal per-scenario checks.
module tb_bus_rx_endpoint;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       bus_valid;
  logic       bus_sof;
  logic [7:0] bus_data;
  logic       rdy [2];
  logic       br  [2];
  logic       ack [2];
  logic       rv  [2];
  logic [7:0] rd  [2];
  logic       rl  [2];
  logic       re  [2];
`ifdef BUS_RX_ERR_CNT_EN
  logic [7:0] ec  [2];
`endif

  bus_rx_endpoint #(.NODE_ID(2'd0), .FIFO_DEPTH(4)) u_ep0 (
    .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_sof(bus_sof),
    .bus_data(bus_data), .bus_ready(br[0]), .bus_ack(ack[0]),
    .rx_valid(rv[0]), .rx_ready(rdy[0]), .rx_data(rd[0]), .rx_last(rl[0]),
    .rx_err(re[0])
`ifdef BUS_RX_ERR_CNT_EN
    , .err_count(ec[0])
`endif
  );

  bus_rx_endpoint #(.NODE_ID(2'd2), .FIFO_DEPTH(4)) u_ep2 (
    .clk(clk), .rst_n(rst_n), .bus_valid(bus_valid), .bus_sof(bus_sof),
    .bus_data(bus_data), .bus_ready(br[1]), .bus_ack(ack[1]),
    .rx_valid(rv[1]), .rx_ready(rdy[1]), .rx_data(rd[1]), .rx_last(rl[1]),
    .rx_err(re[1])
`ifdef BUS_RX_ERR_CNT_EN
    , .err_count(ec[1])
`endif
  );

  int vectors = 0;
  int fails   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  localparam int DEPTH = 4;
  int         nid  [2] = '{0, 2};
  int         gmap [4] = '{0, 1, 3, 2};  // header bits[7:6] -> node number
  int         m_mode [2] = '{0, 0};      // 0 idle, 1 receiving, 2 skipping
  int         m_rem  [2] = '{0, 0};      // bytes still expected after next
  logic [8:0] m_q    [2][$];             // expected FIFO contents {last,data}
  bit         m_ack  [2] = '{0, 0};
  bit         m_err  [2] = '{0, 0};
  bit         seen_rst = 1'b0;

  // DUT-observed logs for literal checks
  logic [8:0] lg   [2][$];
  int         acks [2] = '{0, 0};
  int         errs [2] = '{0, 0};

  function automatic bit exp_ready(input int e);
    if (m_mode[e] == 1) return (m_q[e].size() < DEPTH);
    return (m_mode[e] == 0);
  endfunction

  always @(negedge clk) begin
    bit         do_pop;
    bit         do_push;
    bit         full;
    logic [8:0] ent;
    for (int e = 0; e < 2; e++) begin
      if (seen_rst) begin
        chk($sformatf("ep%0d_bus_ready", nid[e]), br[e], exp_ready(e));
        chk($sformatf("ep%0d_rx_valid", nid[e]), rv[e], m_q[e].size() != 0);
        chk($sformatf("ep%0d_rx_data", nid[e]), rd[e],
            (m_q[e].size() != 0) ? m_q[e][0][7:0] : 8'd0);
        chk($sformatf("ep%0d_rx_last", nid[e]), rl[e],
            (m_q[e].size() != 0) ? m_q[e][0][8] : 1'b0);
        chk($sformatf("ep%0d_bus_ack", nid[e]), ack[e], m_ack[e]);
        chk($sformatf("ep%0d_rx_err", nid[e]), re[e], m_err[e]);
        if (ack[e] === 1'b1) acks[e]++;
        if (re[e] === 1'b1) errs[e]++;
        if (rv[e] === 1'b1 && rdy[e] === 1'b1) lg[e].push_back({rl[e], rd[e]});
      end
      // advance model for the coming rising edge
      if (!rst_n) begin
        m_q[e].delete();
        m_mode[e] = 0;
        m_rem[e]  = 0;
        m_ack[e]  = 1'b0;
        m_err[e]  = 1'b0;
        seen_rst  = 1'b1;
      end else begin
        do_pop  = (m_q[e].size() != 0) && rdy[e];
        full    = (m_q[e].size() >= DEPTH);
        do_push = 1'b0;
        ent     = 9'd0;
        m_ack[e] = 1'b0;
        m_err[e] = 1'b0;
        if (bus_valid && bus_sof) begin
          m_err[e] = (m_mode[e] == 1);
          if (gmap[bus_data[7:6]] == nid[e]) begin
            m_mode[e] = 1;
            m_rem[e]  = int'(bus_data[5:0]);
          end else begin
            m_mode[e] = 2;
          end
        end else if (bus_valid && m_mode[e] == 1 && !full) begin
          do_push = 1'b1;
          ent     = {(m_rem[e] == 0), bus_data};
          if (m_rem[e] == 0) begin
            m_mode[e] = 0;
            m_ack[e]  = 1'b1;
          end else begin
            m_rem[e]--;
          end
        end
        if (do_pop) void'(m_q[e].pop_front());
        if (do_push) m_q[e].push_back(ent);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit sof, input logic [7:0] d, input bit wait_rdy);
    int n;
    n = 0;
    bus_valid = 1'b1;
    bus_sof   = sof;
    bus_data  = d;
    if (wait_rdy) begin
      while (!(br[0] || br[1]) && n < 40) begin
        tick();
        n++;
      end
      chk("bus_ready_wait", (n < 40), 1'b1);
    end
    tick();
    bus_valid = 1'b0;
    bus_sof   = 1'b0;
  endtask

  task automatic clear_logs();
    for (int e = 0; e < 2; e++) begin
      lg[e].delete();
      acks[e] = 0;
      errs[e] = 0;
    end
  endtask

  task automatic check_log(input string nm, input int e, input logic [8:0] ex[$]);
    chk({nm, "_len"}, lg[e].size(), ex.size());
    for (int i = 0; i < ex.size(); i++) begin
      chk({nm, "_byte"}, (i < lg[e].size()) ? lg[e][i] : 9'h1FF, ex[i]);
    end
  endtask

  initial begin
    logic [8:0] ex[$];
    rst_n = 1'b0; bus_valid = 1'b0; bus_sof = 1'b0; bus_data = 8'd0;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_rx_valid", rv[0] | rv[1], 1'b0);

    // S1: NODE_ID 2 receives 3-byte frame
    clear_logs();
    send(1'b1, 8'hC2, 1'b0);
    send(1'b0, 8'h11, 1'b1);
    send(1'b0, 8'h22, 1'b1);
    send(1'b0, 8'h33, 1'b1);
    repeat (4) tick();
    ex = '{9'h011, 9'h022, 9'h133};
    check_log("s1_ep2", 1, ex);
    chk("s1_ep2_acks", acks[1], 1);
    chk("s1_ep0_log_len", lg[0].size(), 0);

    // S2: frame for node 1 skipped by both, dest 3 skipped, then node 2 frame
    clear_logs();
    send(1'b1, 8'h40, 1'b0);
    chk("s2_ready_skip", br[0] | br[1], 1'b0);
    for (int i = 0; i < 4; i++) send(1'b0, 8'h50 + 8'(i), 1'b0);
    send(1'b1, 8'h80, 1'b0);
    send(1'b0, 8'h5F, 1'b0);
    send(1'b1, 8'hC0, 1'b0);
    send(1'b0, 8'hAA, 1'b1);
    repeat (3) tick();
    ex = '{9'h1AA};
    check_log("s2_ep2", 1, ex);
    chk("s2_ep2_acks", acks[1], 1);
    chk("s2_ep0_acks", acks[0], 0);
    chk("s2_ep0_log_len", lg[0].size(), 0);

    // S3: NODE_ID 0, 8 bytes, back-pressure when FIFO fills
    clear_logs();
    rdy[0] = 1'b0;
    send(1'b1, 8'h07, 1'b0);
    for (int i = 0; i < 4; i++) send(1'b0, 8'hA0 + 8'(i), 1'b1);
    chk("s3_full_ready", br[0], 1'b0);
    chk("s3_head_data", rd[0], 8'hA0);
    repeat (3) tick();
    chk("s3_still_full", br[0], 1'b0);
    rdy[0] = 1'b1;
    for (int i = 4; i < 8; i++) send(1'b0, 8'hA0 + 8'(i), 1'b1);
    repeat (8) tick();
    ex = '{9'h0A0, 9'h0A1, 9'h0A2, 9'h0A3, 9'h0A4, 9'h0A5, 9'h0A6, 9'h1A7};
    check_log("s3_ep0", 0, ex);
    chk("s3_ep0_acks", acks[0], 1);

    // S4: abort after 2 of 5 bytes by new 1-byte header
    clear_logs();
    send(1'b1, 8'h04, 1'b0);
    send(1'b0, 8'hB1, 1'b1);
    send(1'b0, 8'hB2, 1'b1);
    send(1'b1, 8'h00, 1'b0);
    send(1'b0, 8'h5A, 1'b1);
    repeat (4) tick();
    ex = '{9'h0B1, 9'h0B2, 9'h15A};
    check_log("s4_ep0", 0, ex);
    chk("s4_ep0_errs", errs[0], 1);
    chk("s4_ep0_acks", acks[0], 1);
    chk("s4_ep2_errs", errs[1], 0);
`ifdef BUS_RX_ERR_CNT_EN
    chk("s4_err_count", ec[0], 8'd1);
`endif

    // S5: reset mid-frame discards buffered bytes, next frame is clean
    clear_logs();
    rdy[0] = 1'b0;
    send(1'b1, 8'h04, 1'b0);
    send(1'b0, 8'hC1, 1'b1);
    send(1'b0, 8'hC2, 1'b1);
    chk("s5_buffered", rv[0], 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("s5_rx_valid", rv[0], 1'b0);
    chk("s5_ack", ack[0], 1'b0);
    rdy[0] = 1'b1;
    send(1'b1, 8'h00, 1'b0);
    send(1'b0, 8'h77, 1'b1);
    repeat (4) tick();
    ex = '{9'h177};
    check_log("s5_ep0", 0, ex);
    chk("s5_ep0_acks", acks[0], 1);
    chk("s5_ep0_errs", errs[0], 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/bus_rx_endpoint.md
BUS_RX_ENDPOINT -- requirements
Module: bus_rx_endpoint

Interface
REQ-001 The block SHALL have parameter NODE_ID, default 2'd0, meaning the binary destination ID this endpoint answers to.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning receive FIFO entries (power of two, 2..16).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  synchronous, active-low reset.
REQ-005 bus_valid  input  1  shared bus carries a byte this cycle.
REQ-006 bus_sof  input  1  qualifies bus_data as a frame header byte; meaningful only with bus_valid.
REQ-007 bus_data  input  8  shared bus byte.
REQ-008 bus_ready  output  1  endpoint accepts the current bus byte; ORed with other endpoints at top level.
REQ-009 bus_ack  output  1  one-cycle pulse: addressed frame fully received.
REQ-010 rx_valid  output  1  FIFO head holds a byte for the local module.
REQ-011 rx_ready  input  1  local module consumes FIFO head.
REQ-012 rx_data  output  8  FIFO head payload byte.
REQ-013 rx_last  output  1  FIFO head is final byte of its frame.
REQ-014 rx_err  output  1  one-cycle pulse: addressed frame aborted.

Function
REQ-015 A bus transfer SHALL occur in a cycle where bus_valid and bus_ready are both 1; a local transfer where rx_valid and rx_ready are both 1.
REQ-016 Header format SHALL be: bits[7:6] Gray-coded destination (00->0, 01->1, 11->2, 10->3), bits[5:0] payload length minus 1 (1..64 bytes).
REQ-017 States SHALL be IDLE, RECV, SKIP.
REQ-018 bus_ready SHALL be 1 in IDLE, !fifo_full in RECV, 0 in SKIP, decoded from registered state only.
REQ-019 In any state, a bus transfer with bus_sof=1 SHALL be taken as a header: decoded destination == NODE_ID -> RECV with remaining count loaded from bits[5:0]; otherwise -> SKIP.
REQ-020 In IDLE, bus_valid with bus_sof=0 SHALL be ignored with no state change and no error.
REQ-021 In RECV, each bus_sof=0 transfer SHALL push {last, bus_data} into the FIFO, last=1 when remaining count is 0; on that last byte state SHALL return to IDLE.
REQ-022 bus_ack SHALL pulse exactly the cycle after the last payload byte's bus transfer.
REQ-023 In SKIP, non-sof bytes SHALL be ignored; only a header leaves SKIP.
REQ-024 A header arriving in RECV before the count completes SHALL pulse rx_err the following cycle, mark the most recently pushed entry (if still in FIFO) unchanged, and start the new frame per REQ-019.
REQ-025 A byte pushed at cycle N SHALL be visible on rx_data with rx_valid=1 at cycle N+1; rx_valid SHALL equal !fifo_empty.
REQ-026 When full, no push SHALL occur even if a pop occurs the same cycle; when not full, simultaneous push and pop SHALL leave occupancy unchanged.
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH with one extra bit distinguishing full from empty.

Reset
REQ-028 On rst_n=0 at a clock edge, state SHALL be IDLE, FIFO empty, count 0, and bus_ack, rx_err, rx_valid, rx_last, rx_data SHALL be 0.
REQ-029 Reset mid-frame SHALL discard all buffered bytes and the partial frame without asserting bus_ack or rx_err.

Configuration
REQ-030 With BUS_RX_ERR_CNT_EN defined, the block SHALL add output err_count (8 bits, reset 0) incrementing once per rx_err pulse, saturating at 255.
REQ-031 Without BUS_RX_ERR_CNT_EN, err_count and its counter SHALL not exist; all other behaviour identical.

Verification
REQ-032 NODE_ID=2, header 8'hC2 then 3 bytes 11,22,33, rx_ready=1 -> rx_data 11,22,33 each one cycle after push, rx_last only on 33, bus_ack one pulse after 33.
REQ-033 Header 8'h40 (dest 1) with NODE_ID=2, then 4 bytes -> bus_ready 0 during bytes, no FIFO push, no bus_ack, state returns via next header.
REQ-034 NODE_ID=0, header 8'h07 (8 bytes), rx_ready=0 -> 4 bytes buffered, bus_ready drops to 0; raise rx_ready -> remaining 4 accepted, order preserved.
REQ-035 Header 8'h04 (5 bytes), after 2 bytes a new sof header 8'h00 -> rx_err pulse once, new 1-byte frame received, bus_ack once; with BUS_RX_ERR_CNT_EN err_count=1.
REQ-036 rst_n=0 for one cycle after 2 of 5 bytes -> FIFO empty, rx_valid 0, no bus_ack/rx_err; next header received normally.
